// File: rtl/iob_merge_arb_pkg.sv
// Shared constants, state encoding and request packing helpers for the
// N-master to 1-slave native-bus merge.
package iob_merge_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // A packed request is laid out {valid, addr, wdata, wstrb}, MSB first.
    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Combinational winner selection: fixed priority (index 0 highest) or
// round robin starting just after the last granted master.
module iob_rr_arbiter
    import iob_merge_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int MODE  = ARB_RR,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    // cand[k] is the master index holding priority rank k (0 = highest).
    logic [SEL_W-1:0] cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            if (MODE == ARB_RR) begin : g_rr
                assign cand[gi] = SEL_W'((int'(last) + gi + 1) % N);
            end else begin : g_fp
                assign cand[gi] = SEL_W'(gi);
            end
        end
    endgenerate

    always_comb begin
        winner  = '0;
        any_req = |req;
        // Scan from lowest rank upward so the highest-ranked requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/iob_merge_arb.sv
// N-master to 1-slave merge for the native valid/ready bus, with
// selectable arbitration and the grant held until slave completion.
module iob_merge_arb
    import iob_merge_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          busy
);

    localparam int SEL_W  = sel_w(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = req_w(ADDR_W, DATA_W);

    state_e           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] last_reg, last_next;
    logic [SEL_W-1:0] winner;
    logic             any_req;

    logic [REQ_W-1:0] req_vec [N_MASTERS];
    logic [REQ_W-1:0] req_sel;
    logic             sel_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_req
            assign req_vec[gi] = {m_valid[gi],
                                  m_addr[gi*ADDR_W +: ADDR_W],
                                  m_wdata[gi*DATA_W +: DATA_W],
                                  m_wstrb[gi*STRB_W +: STRB_W]};
        end
    endgenerate

    assign req_sel   = req_vec[sel_reg];
    assign sel_valid = req_sel[REQ_W-1];
    assign s_addr    = req_sel[REQ_W-2 -: ADDR_W];
    assign s_wdata   = req_sel[DATA_W+STRB_W-1 -: DATA_W];
    assign s_wstrb   = req_sel[STRB_W-1:0];
    assign m_rdata   = {N_MASTERS{s_rdata}};

    iob_rr_arbiter #(
        .N    (N_MASTERS),
        .MODE (ARB_MODE)
    ) u_arb (
        .req     (m_valid),
        .last    (last_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            last_reg  <= SEL_W'(N_MASTERS - 1);
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        s_valid    = 1'b0;
        busy       = 1'b0;
        grant      = '0;
        m_ready    = '0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    sel_next   = winner;
                    last_next  = winner;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy           = 1'b1;
                grant[sel_reg] = 1'b1;
                s_valid        = sel_valid;
                // A master that abandoned its request gets no completion.
                if (sel_valid) begin
                    m_ready[sel_reg] = s_ready;
                end
                if (s_ready || !sel_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
